// File: rtl/bp_cfg_link_decoder.sv
// Config-link slave endpoint: decodes cfg requests into local tile registers and
// forwards IRF/CSR/ucode accesses downstream, returning one response per request.
module bp_cfg_link_decoder #(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int vaddr_width_p    = 39,
    parameter int core_id_width_p  = 4,
    parameter int did_width_p      = 3,
    parameter int cord_width_p     = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_w_i,
    input  logic [cfg_addr_width_p-1:0] req_addr_i,
    input  logic [cfg_data_width_p-1:0] req_data_i,

    output logic                        resp_v_o,
    input  logic                        resp_yumi_i,
    output logic [cfg_data_width_p-1:0] resp_data_o,
    output logic                        resp_err_o,

    output logic                        cfg_reset_o,
    output logic                        freeze_o,
    output logic [core_id_width_p-1:0]  core_id_o,
    output logic [did_width_p-1:0]      did_o,
    output logic [cord_width_p-1:0]     cord_o,
    output logic [1:0]                  icache_mode_o,
    output logic [vaddr_width_p-1:0]    npc_o,
    output logic                        npc_w_v_o,
    output logic [1:0]                  dcache_mode_o,
    output logic [1:0]                  priv_o,
    output logic                        cce_mode_o,

    output logic                        fwd_v_o,
    input  logic                        fwd_ready_i,
    output logic [1:0]                  fwd_tgt_o,
    output logic                        fwd_w_o,
    output logic [cfg_addr_width_p-1:0] fwd_addr_o,
    output logic [cfg_data_width_p-1:0] fwd_data_o,
    input  logic                        fwd_resp_v_i,
    input  logic [cfg_data_width_p-1:0] fwd_resp_data_i
);

    // state     | meaning
    // S_IDLE    | ready for a new request
    // S_FWD_REQ | forwarded request presented, waiting for fwd_ready_i
    // S_FWD_WAIT| forwarded request accepted, waiting for fwd_resp_v_i
    // S_RESP    | response presented, waiting for resp_yumi_i

    localparam int A = cfg_addr_width_p;
    localparam int D = cfg_data_width_p;

    localparam logic [A-1:0] ADDR_RESET   = A'(16'h0001);
    localparam logic [A-1:0] ADDR_FREEZE  = A'(16'h0002);
    localparam logic [A-1:0] ADDR_CORE_ID = A'(16'h0003);
    localparam logic [A-1:0] ADDR_DID     = A'(16'h0004);
    localparam logic [A-1:0] ADDR_CORD    = A'(16'h0005);
    localparam logic [A-1:0] ADDR_IC_ID   = A'(16'h0021);
    localparam logic [A-1:0] ADDR_IC_MODE = A'(16'h0022);
    localparam logic [A-1:0] ADDR_NPC     = A'(16'h0040);
    localparam logic [A-1:0] ADDR_DC_ID   = A'(16'h0041);
    localparam logic [A-1:0] ADDR_DC_MODE = A'(16'h0042);
    localparam logic [A-1:0] ADDR_PRIV    = A'(16'h0043);
    localparam logic [A-1:0] ADDR_CCE_ID  = A'(16'h0080);
    localparam logic [A-1:0] ADDR_CCE_MODE= A'(16'h0081);

    localparam logic [A-1:0] IRF_LO   = A'(16'h0050);
    localparam logic [A-1:0] IRF_HI   = A'(16'h006f);
    localparam logic [A-1:0] CSR_LO   = A'(16'h6000);
    localparam logic [A-1:0] CSR_HI   = A'(16'h6fff);
    localparam logic [A-1:0] UCODE_LO = A'(16'h8000);
    localparam logic [A-1:0] UCODE_HI = A'(16'h8fff);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FWD_REQ  = 2'd1,
        S_FWD_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                       ready_q;
    logic [D-1:0]               resp_data_q, resp_data_d;
    logic                       resp_err_q, resp_err_d;
    logic [1:0]                 fwd_tgt_q, fwd_tgt_d;
    logic                       fwd_w_q, fwd_w_d;
    logic [A-1:0]               fwd_addr_q, fwd_addr_d;
    logic [D-1:0]               fwd_data_q, fwd_data_d;

    logic                       cfg_reset_q;
    logic                       freeze_q;
    logic [core_id_width_p-1:0] core_id_q;
    logic [did_width_p-1:0]     did_q;
    logic [cord_width_p-1:0]    cord_q;
    logic [1:0]                 icache_mode_q;
    logic [vaddr_width_p-1:0]   npc_q;
    logic                       npc_w_v_q;
    logic [1:0]                 dcache_mode_q;
    logic [1:0]                 priv_q;
    logic                       cce_mode_q;

    logic                       accept;
    logic                       loc_hit;
    logic [D-1:0]               loc_rdata;
    logic                       fwd_hit;
    logic [1:0]                 fwd_tgt_dec;
    logic [A-1:0]               fwd_off_dec;

    assign accept = req_v_i && ready_q;

    // Local register map; the cache/CCE id aliases are read-only views of core_id.
    always_comb begin
        loc_hit   = 1'b1;
        loc_rdata = '0;
        case (req_addr_i)
            ADDR_RESET:    loc_rdata = D'(cfg_reset_q);
            ADDR_FREEZE:   loc_rdata = D'(freeze_q);
            ADDR_CORE_ID:  loc_rdata = D'(core_id_q);
            ADDR_DID:      loc_rdata = D'(did_q);
            ADDR_CORD:     loc_rdata = D'(cord_q);
            ADDR_IC_ID:    loc_rdata = D'(core_id_q);
            ADDR_IC_MODE:  loc_rdata = D'(icache_mode_q);
            ADDR_NPC:      loc_rdata = D'(npc_q);
            ADDR_DC_ID:    loc_rdata = D'(core_id_q);
            ADDR_DC_MODE:  loc_rdata = D'(dcache_mode_q);
            ADDR_PRIV:     loc_rdata = D'(priv_q);
            ADDR_CCE_ID:   loc_rdata = D'(core_id_q);
            ADDR_CCE_MODE: loc_rdata = D'(cce_mode_q);
            default:       loc_hit   = 1'b0;
        endcase
    end

    always_comb begin
        fwd_hit     = 1'b1;
        fwd_tgt_dec = 2'd0;
        fwd_off_dec = '0;
        if (req_addr_i >= IRF_LO && req_addr_i <= IRF_HI) begin
            fwd_tgt_dec = 2'd0;
            fwd_off_dec = req_addr_i - IRF_LO;
        end else if (req_addr_i >= CSR_LO && req_addr_i <= CSR_HI) begin
            fwd_tgt_dec = 2'd1;
            fwd_off_dec = req_addr_i - CSR_LO;
        end else if (req_addr_i >= UCODE_LO && req_addr_i <= UCODE_HI) begin
            fwd_tgt_dec = 2'd2;
            fwd_off_dec = req_addr_i - UCODE_LO;
        end else begin
            fwd_hit = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        fwd_tgt_d   = fwd_tgt_q;
        fwd_w_d     = fwd_w_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (loc_hit) begin
                        resp_data_d = req_w_i ? '0 : loc_rdata;
                        resp_err_d  = 1'b0;
                        state_d     = S_RESP;
                    end else if (fwd_hit) begin
                        fwd_tgt_d   = fwd_tgt_dec;
                        fwd_w_d     = req_w_i;
                        fwd_addr_d  = fwd_off_dec;
                        fwd_data_d  = req_data_i;
                        state_d     = S_FWD_REQ;
                    end else begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_FWD_REQ: begin
                // A downstream response in the handshake cycle skips the wait state.
                if (fwd_ready_i) begin
                    if (fwd_resp_v_i) begin
                        resp_data_d = fwd_w_q ? '0 : fwd_resp_data_i;
                        resp_err_d  = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        state_d     = S_FWD_WAIT;
                    end
                end
            end
            S_FWD_WAIT: begin
                if (fwd_resp_v_i) begin
                    resp_data_d = fwd_w_q ? '0 : fwd_resp_data_i;
                    resp_err_d  = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_yumi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            fwd_tgt_q   <= 2'd0;
            fwd_w_q     <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == S_IDLE);
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            fwd_tgt_q   <= fwd_tgt_d;
            fwd_w_q     <= fwd_w_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cfg_reset_q   <= 1'b1;
            freeze_q      <= 1'b1;
            core_id_q     <= '0;
            did_q         <= '0;
            cord_q        <= '0;
            icache_mode_q <= 2'b00;
            npc_q         <= '0;
            npc_w_v_q     <= 1'b0;
            dcache_mode_q <= 2'b00;
            priv_q        <= 2'b11;
            cce_mode_q    <= 1'b0;
        end else begin
            npc_w_v_q <= accept && req_w_i && (req_addr_i == ADDR_NPC);
            if (accept && req_w_i) begin
                case (req_addr_i)
                    ADDR_RESET:    cfg_reset_q   <= req_data_i[0];
                    ADDR_FREEZE:   freeze_q      <= req_data_i[0];
                    ADDR_CORE_ID:  core_id_q     <= req_data_i[core_id_width_p-1:0];
                    ADDR_DID:      did_q         <= req_data_i[did_width_p-1:0];
                    ADDR_CORD:     cord_q        <= req_data_i[cord_width_p-1:0];
                    ADDR_IC_MODE:  icache_mode_q <= req_data_i[1:0];
                    ADDR_NPC:      npc_q         <= req_data_i[vaddr_width_p-1:0];
                    ADDR_DC_MODE:  dcache_mode_q <= req_data_i[1:0];
                    ADDR_PRIV:     priv_q        <= req_data_i[1:0];
                    ADDR_CCE_MODE: cce_mode_q    <= req_data_i[0];
                    default: ;
                endcase
            end
        end
    end

    assign req_ready_o   = ready_q;
    assign resp_v_o      = (state_q == S_RESP);
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;

    assign fwd_v_o       = (state_q == S_FWD_REQ);
    assign fwd_tgt_o     = fwd_tgt_q;
    assign fwd_w_o       = fwd_w_q;
    assign fwd_addr_o    = fwd_addr_q;
    assign fwd_data_o    = fwd_data_q;

    assign cfg_reset_o   = cfg_reset_q;
    assign freeze_o      = freeze_q;
    assign core_id_o     = core_id_q;
    assign did_o         = did_q;
    assign cord_o        = cord_q;
    assign icache_mode_o = icache_mode_q;
    assign npc_o         = npc_q;
    assign npc_w_v_o     = npc_w_v_q;
    assign dcache_mode_o = dcache_mode_q;
    assign priv_o        = priv_q;
    assign cce_mode_o    = cce_mode_q;

endmodule

// File: tb/tb_bp_cfg_link_decoder.sv
// Scoreboard bench for bp_cfg_link_decoder: table-driven register model,
// downstream stub with programmable delays, and a decoupled response monitor.
module tb_bp_cfg_link_decoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        req_v_i = 1'b0, req_ready_o, req_w_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic        resp_v_o, resp_yumi_i = 1'b0, resp_err_o;
    logic [63:0] resp_data_o;
    logic        cfg_reset_o, freeze_o, npc_w_v_o, cce_mode_o;
    logic [3:0]  core_id_o;
    logic [2:0]  did_o;
    logic [7:0]  cord_o;
    logic [1:0]  icache_mode_o, dcache_mode_o, priv_o;
    logic [38:0] npc_o;
    logic        fwd_v_o, fwd_ready_i = 1'b0, fwd_w_o, fwd_resp_v_i = 1'b0;
    logic [1:0]  fwd_tgt_o;
    logic [15:0] fwd_addr_o;
    logic [63:0] fwd_data_o, fwd_resp_data_i = '0;

    always #5 clk_i = ~clk_i;

    bp_cfg_link_decoder dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .cfg_reset_o(cfg_reset_o), .freeze_o(freeze_o), .core_id_o(core_id_o),
        .did_o(did_o), .cord_o(cord_o), .icache_mode_o(icache_mode_o),
        .npc_o(npc_o), .npc_w_v_o(npc_w_v_o), .dcache_mode_o(dcache_mode_o),
        .priv_o(priv_o), .cce_mode_o(cce_mode_o),
        .fwd_v_o(fwd_v_o), .fwd_ready_i(fwd_ready_i), .fwd_tgt_o(fwd_tgt_o),
        .fwd_w_o(fwd_w_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
        .fwd_resp_v_i(fwd_resp_v_i), .fwd_resp_data_i(fwd_resp_data_i)
    );

    logic [62:0] dut_regs;
    assign dut_regs = {cfg_reset_o, freeze_o, core_id_o, did_o, cord_o, icache_mode_o,
                       npc_o, dcache_mode_o, priv_o, cce_mode_o};

    typedef struct { logic [63:0] data; logic err; logic [62:0] regs; } exp_t;
    typedef struct { logic [1:0] tgt; logic [15:0] off; logic w; logic [63:0] data; } fwd_t;

    exp_t sb[$];
    fwd_t fq[$];

    int total = 0;
    int bad   = 0;

    int          yumi_hold      = -1;
    int          stub_ready_dly = -1;
    int          stub_resp_dly  = -1;
    logic        stub_fixed     = 1'b0;
    logic [63:0] stub_data      = '0;

    // Reference model: register map as address -> field width, aliases -> core id.
    int unsigned wid[int];
    bit          alias_a[int];
    logic [63:0] val[int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        val.delete();
        foreach (wid[k]) val[k] = 64'd0;
        val[1]     = 64'd1;
        val[2]     = 64'd1;
        val['h43]  = 64'd3;
    endfunction

    function automatic logic [62:0] snap();
        logic [63:0] r1, r2, r3, r4, r5, r22, r40, r42, r43, r81;
        r1 = val[1]; r2 = val[2]; r3 = val[3]; r4 = val[4]; r5 = val[5];
        r22 = val['h22]; r40 = val['h40]; r42 = val['h42]; r43 = val['h43]; r81 = val['h81];
        return {r1[0], r2[0], r3[3:0], r4[2:0], r5[7:0], r22[1:0], r40[38:0],
                r42[1:0], r43[1:0], r81[0]};
    endfunction

    function automatic logic [63:0] stub_read(input logic [1:0] tgt, input logic [15:0] off);
        if (stub_fixed) return stub_data;
        return {16'hC0DE, 14'd0, tgt, off, 16'h5A5A};
    endfunction

    function automatic void model_access(input logic w, input logic [15:0] a, input logic [63:0] d,
                                         output exp_t e, output logic isf, output fwd_t f);
        int ai;
        ai    = int'(a);
        e.data = '0;
        e.err  = 1'b0;
        isf    = 1'b0;
        f      = '{tgt: 2'd0, off: 16'd0, w: w, data: d};
        if (alias_a.exists(ai)) begin
            if (!w) e.data = val[3];
        end else if (wid.exists(ai)) begin
            if (w) val[ai] = d & ((64'd1 << wid[ai]) - 64'd1);
            else   e.data  = val[ai];
        end else if (a >= 16'h0050 && a <= 16'h006f) begin
            isf = 1'b1; f.tgt = 2'd0; f.off = a - 16'h0050;
        end else if (a >= 16'h6000 && a <= 16'h6fff) begin
            isf = 1'b1; f.tgt = 2'd1; f.off = a - 16'h6000;
        end else if (a >= 16'h8000 && a <= 16'h8fff) begin
            isf = 1'b1; f.tgt = 2'd2; f.off = a - 16'h8000;
        end else begin
            e.err = 1'b1;
        end
        if (isf && !w) e.data = stub_read(f.tgt, f.off);
        e.regs = snap();
    endfunction

    task automatic do_req(input logic w, input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        fwd_t f;
        logic isf;
        int   n;
        @(posedge clk_i); #1;
        req_v_i = 1'b1; req_w_i = w; req_addr_i = a; req_data_i = d;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 100) begin @(negedge clk_i); n++; end
        if (!req_ready_o) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_v_i = 1'b0;
            return;
        end
        model_access(w, a, d, e, isf, f);
        sb.push_back(e);
        if (isf) fq.push_back(f);
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        @(negedge clk_i);
        chk("npc_w_pulse", {63'd0, npc_w_v_o}, {63'd0, (w && a == 16'h0040)});
        if (isf) chk("fwd_v_latency", {63'd0, fwd_v_o}, 64'd1);
        else     chk("resp_v_latency", {63'd0, resp_v_o}, 64'd1);
        n = 0;
        while (!(req_ready_o && sb.size() == 0) && n < 100) begin
            @(negedge clk_i);
            n++;
            chk("npc_w_idle", {63'd0, npc_w_v_o}, 64'd0);
        end
        if (n >= 100) chk("complete_timeout", 64'd0, 64'd1);
    endtask

    // Response monitor: compares the head of the scoreboard every cycle the response is held.
    initial begin : monitor
        int held;
        held = 0;
        forever begin
            @(negedge clk_i);
            resp_yumi_i = 1'b0;
            if (reset_n_i && resp_v_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {63'd0, resp_v_o}, 64'd0);
                end else begin
                    chk("resp_data", resp_data_o, sb[0].data);
                    chk("resp_err", {63'd0, resp_err_o}, {63'd0, sb[0].err});
                    chk("regs", {1'b0, dut_regs}, {1'b0, sb[0].regs});
                    chk("ready_in_resp", {63'd0, req_ready_o}, 64'd0);
                    held++;
                    if ((yumi_hold >= 0) ? (held > yumi_hold) : ($urandom_range(0, 1) == 1)) begin
                        resp_yumi_i = 1'b1;
                        void'(sb.pop_front());
                        held = 0;
                    end
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic chk_fwd();
        if (fq.size() == 0) begin
            chk("unexpected_fwd", {63'd0, fwd_v_o}, 64'd0);
        end else begin
            chk("fwd_v_held", {63'd0, fwd_v_o}, 64'd1);
            chk("fwd_tgt", {62'd0, fwd_tgt_o}, {62'd0, fq[0].tgt});
            chk("fwd_addr", {48'd0, fwd_addr_o}, {48'd0, fq[0].off});
            chk("fwd_w", {63'd0, fwd_w_o}, {63'd0, fq[0].w});
            chk("fwd_data", fwd_data_o, fq[0].data);
        end
    endtask

    // Downstream stub: delayed ready, then a response 0..N cycles after the handshake.
    initial begin : stub
        int          rd, rp;
        logic [63:0] rdat;
        forever begin
            @(negedge clk_i);
            if (reset_n_i && fwd_v_o) begin
                rd = (stub_ready_dly >= 0) ? stub_ready_dly : int'($urandom_range(0, 3));
                rp = (stub_resp_dly  >= 0) ? stub_resp_dly  : int'($urandom_range(0, 3));
                chk_fwd();
                for (int i = 0; i < rd; i++) begin
                    @(negedge clk_i);
                    chk_fwd();
                end
                rdat = fwd_w_o ? {$urandom, $urandom} : stub_read(fwd_tgt_o, fwd_addr_o);
                fwd_ready_i = 1'b1;
                if (rp == 0) begin
                    fwd_resp_v_i    = 1'b1;
                    fwd_resp_data_i = rdat;
                end
                @(negedge clk_i);
                fwd_ready_i  = 1'b0;
                fwd_resp_v_i = 1'b0;
                if (fq.size() > 0) void'(fq.pop_front());
                if (rp > 0) begin
                    repeat (rp - 1) @(negedge clk_i);
                    fwd_resp_v_i    = 1'b1;
                    fwd_resp_data_i = rdat;
                    @(negedge clk_i);
                    fwd_resp_v_i = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    logic [15:0] addr_pool [0:27];

    initial begin : main
        exp_t e;
        fwd_t f;
        logic isf;
        logic [15:0] a;

        wid[1] = 1; wid[2] = 1; wid[3] = 4; wid[4] = 3; wid[5] = 8;
        wid['h22] = 2; wid['h40] = 39; wid['h42] = 2; wid['h43] = 2; wid['h81] = 1;
        alias_a['h21] = 1'b1; alias_a['h41] = 1'b1; alias_a['h80] = 1'b1;
        model_reset();

        addr_pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0021,
                      16'h0022, 16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0080, 16'h0081,
                      16'h004f, 16'h0050, 16'h006f, 16'h0070, 16'h5fff, 16'h6000, 16'h6fff,
                      16'h7000, 16'h7fff, 16'h8000, 16'h8fff, 16'h9000, 16'hffff, 16'h0007};

        // Reset state
        #12;
        chk("rst_ready", {63'd0, req_ready_o}, 64'd0);
        chk("rst_resp_v", {63'd0, resp_v_o}, 64'd0);
        chk("rst_fwd_v", {63'd0, fwd_v_o}, 64'd0);
        chk("rst_npc_w", {63'd0, npc_w_v_o}, 64'd0);
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rel_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rel_cfg_reset", {63'd0, cfg_reset_o}, 64'd1);
        chk("rel_freeze", {63'd0, freeze_o}, 64'd1);
        chk("rel_priv", {62'd0, priv_o}, 64'd3);
        chk("rel_regs", {1'b0, dut_regs}, {1'b0, snap()});

        yumi_hold = 0; stub_ready_dly = 0; stub_resp_dly = 1;
        do_req(1'b1, 16'h0002, 64'd0);
        chk("freeze_cleared", {63'd0, freeze_o}, 64'd0);

        do_req(1'b1, 16'h0040, 64'h8000_0000);
        chk("npc_value", {25'd0, npc_o}, 64'h8000_0000);
        do_req(1'b0, 16'h0040, 64'd0);

        do_req(1'b1, 16'h0003, 64'd5);
        do_req(1'b0, 16'h0021, 64'd0);
        do_req(1'b0, 16'h0041, 64'd0);
        do_req(1'b0, 16'h0080, 64'd0);
        do_req(1'b1, 16'h0041, 64'd9);
        chk("core_id_kept", {60'd0, core_id_o}, 64'd5);
        do_req(1'b0, 16'h0003, 64'd0);

        stub_ready_dly = 3; stub_resp_dly = 2; stub_fixed = 1'b1; stub_data = 64'hABCD;
        do_req(1'b0, 16'h6010, 64'd0);
        stub_fixed = 1'b0;
        do_req(1'b1, 16'h8004, 64'h1234_5678_9abc_def0);
        stub_ready_dly = 0; stub_resp_dly = 0;
        do_req(1'b0, 16'h006f, 64'd0);

        yumi_hold = 4;
        do_req(1'b0, 16'h0007, 64'd0);
        do_req(1'b1, 16'h0007, 64'hFFFF);

        // Randomized traffic
        yumi_hold = -1; stub_ready_dly = -1; stub_resp_dly = -1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addr_pool[$urandom_range(0, 27)];
            do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        // Async reset while a forwarded request waits for its response
        yumi_hold = 0; stub_ready_dly = 0; stub_resp_dly = 6;
        do_req(1'b1, 16'h0002, 64'd0);
        @(posedge clk_i); #1;
        req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 16'h6020; req_data_i = '0;
        @(negedge clk_i);
        chk("rst_tx_ready", {63'd0, req_ready_o}, 64'd1);
        model_access(1'b0, 16'h6020, 64'd0, e, isf, f);
        sb.push_back(e);
        fq.push_back(f);
        @(posedge clk_i); #1;
        req_v_i = 1'b0;
        @(negedge clk_i);
        chk("rst_tx_fwd_req", {63'd0, fwd_v_o}, 64'd1);
        @(negedge clk_i);
        chk("rst_tx_wait_fwd", {63'd0, fwd_v_o}, 64'd0);
        chk("rst_tx_wait_resp", {63'd0, resp_v_o}, 64'd0);
        chk("rst_tx_wait_ready", {63'd0, req_ready_o}, 64'd0);
        @(posedge clk_i); #3;
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_fwd_v", {63'd0, fwd_v_o}, 64'd0);
        chk("mid_rst_resp_v", {63'd0, resp_v_o}, 64'd0);
        chk("mid_rst_freeze", {63'd0, freeze_o}, 64'd1);
        sb.delete();
        model_reset();
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("late_resp_ignored", {63'd0, resp_v_o}, 64'd0);
            chk("no_fwd_after_rst", {63'd0, fwd_v_o}, 64'd0);
        end
        chk("post_rst_regs", {1'b0, dut_regs}, {1'b0, snap()});
        chk("post_rst_ready", {63'd0, req_ready_o}, 64'd1);

        stub_resp_dly = 1;
        do_req(1'b0, 16'h0043, 64'd0);
        do_req(1'b0, 16'h8fff, 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("fq_drained", 64'(fq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
